// File: rtl/servo_pwm_gen.sv
// ---------------------------------------------------------------------------
// servo_pwm_gen
// Turns an 8-bit servo position word into a hobby-servo PWM waveform. Each
// frame is PERIOD_CYC clocks long. The pulse starts on the first cycle of the
// frame and is MIN_CYC + position*SCALE clocks wide. A new position is taken
// only at a frame boundary, so a pulse never changes while it is being driven.
// When MAX_STEP is nonzero, the applied position moves toward the target by at
// most MAX_STEP units per frame.
//
// Ports
//   clk          : system clock, rising edge
//   reset        : synchronous, active-high reset
//   enable       : run request, looked at only on frame boundaries
//   position_in  : target position (unsigned, 0..255)
//   pwm_out      : registered servo drive
//   frame_start  : one-cycle pulse on the first cycle of each frame
//   cur_position : position applied to the current frame
//   at_target    : applied position equals the target taken at last boundary
// ---------------------------------------------------------------------------
module servo_pwm_gen #(
   parameter int PERIOD_CYC = 1000000,
   parameter int MIN_CYC    = 50000,
   parameter int MAX_CYC    = 100000,
   parameter int MAX_STEP   = 0,
   parameter int INIT_POS   = 128
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] position_in,
   output logic       pwm_out,
   output logic       frame_start,
   output logic [7:0] cur_position,
   output logic       at_target
);

   localparam int SCALE = (MAX_CYC - MIN_CYC) / 255;
   // A legal setting always has PERIOD_CYC > 255, so CW is at least 8 and the
   // widest pulse (which is below PERIOD_CYC) also fits in CW bits.
   localparam int CW    = $clog2(PERIOD_CYC);
   // Any step above 255 behaves like "no limit", so it is clamped to 8 bits.
   localparam int STEP  = (MAX_STEP > 255) ? 255 : MAX_STEP;

   localparam logic [CW-1:0] LAST  = CW'(PERIOD_CYC - 1);
   localparam logic [8:0]    STEP9 = 9'(STEP);
   localparam logic [7:0]    STEP8 = 8'(STEP);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] width_q;
   logic [7:0]    cur_q;
   logic          pwm_q;
   logic          fs_q;
   logic          at_q;

   logic [8:0]    diff;
   logic [8:0]    mag;
   logic [7:0]    cur_d;
   logic [CW-1:0] width_d;
   logic          at_d;
   logic [CW-1:0] cntNext;

   // These are the values that a boundary would load. They are computed every
   // cycle and used only when a boundary is actually processed. The difference
   // is the 9-bit two's-complement value target - current, so its MSB tells
   // which way to step.
   always_comb begin
      diff    = {1'b0, position_in} - {1'b0, cur_q};
      mag     = diff[8] ? (9'd0 - diff) : diff;
      cur_d   = position_in;
      if ((STEP != 0) && (mag > STEP9)) begin
         cur_d = diff[8] ? (cur_q - STEP8) : (cur_q + STEP8);
      end
      width_d = CW'(MIN_CYC) + CW'(cur_d) * CW'(SCALE);
      at_d    = (cur_d == position_in);
      cntNext = cnt_q + CW'(1);
   end

   // The frame FSM. Every output is registered and already holds the value for
   // the cycle it is seen in. This means pwm_out for counter value n is
   // decided while the counter still holds n-1, or while the boundary is
   // being processed when n is 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         width_q <= '0;
         cur_q   <= 8'(INIT_POS);
         pwm_q   <= 1'b0;
         fs_q    <= 1'b0;
         at_q    <= 1'b0;
      end else begin
         fs_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               pwm_q <= 1'b0;
               if (enable) begin
                  cur_q   <= cur_d;
                  width_q <= width_d;
                  at_q    <= at_d;
                  state_q <= RUN;
                  fs_q    <= 1'b1;
                  pwm_q   <= (width_d != '0);
               end
            end
            RUN: begin
               if (cnt_q == LAST) begin
                  cur_q   <= cur_d;
                  width_q <= width_d;
                  at_q    <= at_d;
                  cnt_q   <= '0;
                  if (enable) begin
                     fs_q  <= 1'b1;
                     pwm_q <= (width_d != '0);
                  end else begin
                     state_q <= IDLE;
                     pwm_q   <= 1'b0;
                  end
               end else begin
                  cnt_q <= cntNext;
                  pwm_q <= (cntNext < width_q);
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               pwm_q   <= 1'b0;
            end
         endcase
      end
   end

   assign pwm_out      = pwm_q;
   assign frame_start  = fs_q;
   assign cur_position = cur_q;
   assign at_target    = at_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// ---------------------------------------------------------------------------
// tb_servo_pwm_gen
// Directed bench for servo_pwm_gen, built with a 2000-cycle frame,
// MIN_CYC=255 and SCALE=2. Instance dut has no slew limit. Instance dutSlew
// limits each frame to a step of 10 and is held in reset until it is used.
// ---------------------------------------------------------------------------
module tb_servo_pwm_gen;

   localparam int PERIOD = 2000;

   logic       clock;
   logic       reset, enable;
   logic [7:0] position;
   logic       pwm, fs, at;
   logic [7:0] cur;

   logic       reset2, enable2;
   logic [7:0] position2;
   logic       pwm2, fs2, at2;
   logic [7:0] cur2;

   logic       sel;
   logic       obsPwm, obsFs, obsAt;
   logic [7:0] obsCur;

   int testsRun  = 0;
   int testsFail = 0;

   servo_pwm_gen #(
      .PERIOD_CYC(PERIOD), .MIN_CYC(255), .MAX_CYC(765), .MAX_STEP(0), .INIT_POS(128)
   ) dut (
      .clk(clock), .reset(reset), .enable(enable), .position_in(position),
      .pwm_out(pwm), .frame_start(fs), .cur_position(cur), .at_target(at)
   );

   servo_pwm_gen #(
      .PERIOD_CYC(PERIOD), .MIN_CYC(255), .MAX_CYC(765), .MAX_STEP(10), .INIT_POS(128)
   ) dutSlew (
      .clk(clock), .reset(reset2), .enable(enable2), .position_in(position2),
      .pwm_out(pwm2), .frame_start(fs2), .cur_position(cur2), .at_target(at2)
   );

   // The measuring tasks watch whichever instance sel picks.
   assign obsPwm = sel ? pwm2 : pwm;
   assign obsFs  = sel ? fs2  : fs;
   assign obsAt  = sel ? at2  : at;
   assign obsCur = sel ? cur2 : cur;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      testsRun++;
      if (observed !== expected) begin
         testsFail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic en, input logic [7:0] pos);
      if (sel) begin
         reset2 = rst; enable2 = en; position2 = pos;
      end else begin
         reset = rst; enable = en; position = pos;
      end
   endtask

   // Waits for a frame_start. A timeout counts as a failed comparison.
   task automatic waitFrameStart(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!obsFs && n < 2500);
      if (!obsFs) checkOutput(tag, 0, 1);
   endtask

   // Call this on the negedge of a frame_start cycle. It measures the frame
   // until the next frame_start and can change the position at a given counter
   // value (-1 means no change).
   task automatic measureFrame(input int changeAt, input logic [7:0] newPos,
                               output int high, output int len,
                               output int curAtStart, output int atAtStart,
                               output int pwmAtStart);
      high = 0; len = 0;
      curAtStart = int'(obsCur);
      atAtStart  = int'(obsAt);
      pwmAtStart = int'(obsPwm);
      do begin
         if (len == changeAt) applyStimulus(1'b0, 1'b1, newPos);
         if (obsPwm) high++;
         len++;
         @(negedge clock);
      end while (!obsFs && len < 2500);
   endtask

   int high, len, c0, a0, p0, bad;

   initial begin
      sel = 1'b0;
      reset = 1'b1; enable = 1'b0; position = 8'd0;
      reset2 = 1'b1; enable2 = 1'b0; position2 = 8'd0;
      repeat (3) @(negedge clock);

      // Reset state
      checkOutput("rst_pwm", pwm, 0);
      checkOutput("rst_fs", fs, 0);
      checkOutput("rst_at", at, 0);
      checkOutput("rst_cur", cur, 128);

      // Test 1: position 0 gives a 255-cycle pulse
      applyStimulus(1'b0, 1'b1, 8'd0);
      @(negedge clock);
      checkOutput("t1_first_fs", fs, 1);
      checkOutput("t1_first_pwm", pwm, 1);
      measureFrame(-1, 8'd0, high, len, c0, a0, p0);
      checkOutput("t1_cur", c0, 0);
      checkOutput("t1_at", a0, 1);
      checkOutput("t1_high", high, 255);
      checkOutput("t1_len", len, PERIOD);

      // Test 2: 255 -> 765 cycles from the next frame, then 128 -> 511
      measureFrame(0, 8'd255, high, len, c0, a0, p0);
      checkOutput("t2_latency_high", high, 255);
      checkOutput("t2_len", len, PERIOD);
      measureFrame(0, 8'd128, high, len, c0, a0, p0);
      checkOutput("t2_255_high", high, 765);
      checkOutput("t2_255_cur", c0, 255);
      checkOutput("t2_255_rise", p0, 1);
      measureFrame(0, 8'd0, high, len, c0, a0, p0);
      checkOutput("t2_128_high", high, 511);
      checkOutput("t2_128_cur", c0, 128);

      // Test 3: a change in mid-frame waits for the next boundary
      measureFrame(-1, 8'd0, high, len, c0, a0, p0);
      checkOutput("t3_pre_high", high, 255);
      measureFrame(500, 8'd100, high, len, c0, a0, p0);
      checkOutput("t3_cur_frame_high", high, 255);
      measureFrame(-1, 8'd0, high, len, c0, a0, p0);
      checkOutput("t3_next_high", high, 455);
      checkOutput("t3_next_cur", c0, 100);
      checkOutput("t3_next_at", a0, 1);

      // Test 4: dropping enable mid-frame still completes that frame
      high = 0;
      for (int i = 0; i < PERIOD; i++) begin
         if (i == 100) applyStimulus(1'b0, 1'b0, 8'd100);
         if (pwm) high++;
         if (i > 0 && fs) high += 10000;
         @(negedge clock);
      end
      checkOutput("t5_last_high", high, 455);
      bad = 0;
      for (int i = 0; i < 500; i++) begin
         if (fs || pwm) bad++;
         @(negedge clock);
      end
      checkOutput("t5_idle_quiet", bad, 0);
      applyStimulus(1'b0, 1'b1, 8'd100);
      @(negedge clock);
      checkOutput("t5_restart_fs", fs, 1);
      checkOutput("t5_restart_pwm", pwm, 1);

      // Test 5: reset in the middle of a 511-cycle pulse
      measureFrame(0, 8'd128, high, len, c0, a0, p0);
      checkOutput("t6_pre_high", high, 455);
      checkOutput("t6_pre_len", len, PERIOD);
      checkOutput("t6_at_before", at, 1);
      repeat (50) @(negedge clock);
      checkOutput("t6_mid_pwm", pwm, 1);
      applyStimulus(1'b1, 1'b1, 8'd200);
      @(negedge clock);
      checkOutput("t6_rst_pwm", pwm, 0);
      checkOutput("t6_rst_cur", cur, 128);
      checkOutput("t6_rst_at", at, 0);
      checkOutput("t6_rst_fs", fs, 0);
      bad = 0;
      repeat (3) begin
         @(negedge clock);
         if (fs || pwm) bad++;
      end
      applyStimulus(1'b0, 1'b0, 8'd200);
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if (fs || pwm) bad++;
      end
      checkOutput("t6_no_frame", bad, 0);

      // Test 6: with a slew limit of 10, 128 steps up to 200
      sel = 1'b1;
      applyStimulus(1'b0, 1'b1, 8'd200);
      waitFrameStart("t4_timeout");
      for (int k = 1; k <= 8; k++) begin
         int expCur;
         expCur = (128 + 10 * k > 200) ? 200 : 128 + 10 * k;
         measureFrame(-1, 8'd200, high, len, c0, a0, p0);
         checkOutput($sformatf("t4_cur_%0d", k), c0, expCur);
         checkOutput($sformatf("t4_high_%0d", k), high, 255 + 2 * expCur);
         checkOutput($sformatf("t4_at_%0d", k), a0, (expCur == 200) ? 1 : 0);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
      $finish;
   end

endmodule
